// File: rtl/synth_pkg.sv
// Shared synth definitions: note increment table at 40 kHz, oscillator state encoding.
package synth_pkg;

  localparam int SAMPLE_RATE_HZ = 40000;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} osc_state_t;

  // round(f * 2^24 / 40000) for C4..B4; index 9 is A4 = 440 Hz
  localparam logic [23:0] NOTE_INC [0:11] = '{
    24'h01ACA6, 24'h01C623, 24'h01E124, 24'h01FDC0,
    24'h021C10, 24'h023C2D, 24'h025E33, 24'h02823F,
    24'h02A86F, 24'h02D0E5, 24'h02FBC3, 24'h03292E
  };

  function automatic logic [3:0] clamp_note(input logic [3:0] n);
    return (n > 4'd11) ? 4'd11 : n;
  endfunction

endpackage

// File: rtl/note_inc_lut.sv
// Combinational note/octave to per-sample phase increment; out-of-range notes map to B.
module note_inc_lut
  import synth_pkg::*;
(
  input  logic [3:0]  i_note_idx,
  input  logic [1:0]  i_octave,
  output logic [23:0] o_tgt_inc
);

  logic [3:0]  w_note;
  logic [23:0] w_base;

  assign w_note    = clamp_note(i_note_idx);
  assign w_base    = NOTE_INC[w_note];
  assign o_tgt_inc = w_base << i_octave;

endmodule

// File: rtl/phase_oscillator.sv
// Sawtooth phase accumulator, one step per sample_tick, saw_valid one cycle after the tick.
// Optional glide between notes when PORTAMENTO_EN is defined; otherwise a note change retriggers.
module phase_oscillator
  import synth_pkg::*;
#(
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 8,
  parameter int GLIDE_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             key_on,
  input  logic [3:0]       note_idx,
  input  logic [1:0]       octave,
  output logic [OUT_W-1:0] saw_out,
  output logic             saw_valid,
  output logic             wrap
);

  osc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_cur_inc;
  logic [3:0]       r_note;
  logic [1:0]       r_oct;

  logic [23:0]      w_lut_inc;
  logic [ACC_W-1:0] w_tgt_inc;
  logic [ACC_W:0]   w_sum;
  logic             w_note_chg;

  note_inc_lut u_lut (
    .i_note_idx (note_idx),
    .i_octave   (octave),
    .o_tgt_inc  (w_lut_inc)
  );

  assign w_tgt_inc  = ACC_W'(w_lut_inc);
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_cur_inc};
  assign w_note_chg = (clamp_note(note_idx) != r_note) || (octave != r_oct);

`ifdef PORTAMENTO_EN
  logic [ACC_W-1:0] r_tgt_inc;
  logic [ACC_W-1:0] w_diff;
  logic [ACC_W-1:0] w_shr;
  logic [ACC_W-1:0] w_step;
  logic [ACC_W-1:0] w_glide_inc;
  logic             w_up;

  // Step is never larger than the remaining distance, so the glide cannot overshoot.
  assign w_up        = (r_tgt_inc >= r_cur_inc);
  assign w_diff      = w_up ? (r_tgt_inc - r_cur_inc) : (r_cur_inc - r_tgt_inc);
  assign w_shr       = w_diff >> GLIDE_SHIFT;
  assign w_step      = (w_shr == '0) ? ACC_W'(1) : w_shr;
  assign w_glide_inc = (w_diff == '0) ? r_cur_inc :
                       (w_up ? (r_cur_inc + w_step) : (r_cur_inc - w_step));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cur_inc <= '0;
      r_note    <= '0;
      r_oct     <= '0;
      saw_out   <= '0;
      saw_valid <= 1'b0;
      wrap      <= 1'b0;
`ifdef PORTAMENTO_EN
      r_tgt_inc <= '0;
`endif
    end else begin
      saw_valid <= 1'b0;
      wrap      <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc   <= '0;
          saw_out <= '0;
          if (key_on) r_state <= LOAD;
        end
        LOAD: begin
          r_acc     <= '0;
          r_cur_inc <= w_tgt_inc;
          r_note    <= clamp_note(note_idx);
          r_oct     <= octave;
          r_state   <= RUN;
`ifdef PORTAMENTO_EN
          r_tgt_inc <= w_tgt_inc;
`endif
        end
        RUN: begin
          if (!key_on) begin
            r_state <= IDLE;
            r_acc   <= '0;
            saw_out <= '0;
          end else begin
`ifdef PORTAMENTO_EN
            if (w_note_chg) begin
              r_note    <= clamp_note(note_idx);
              r_oct     <= octave;
              r_tgt_inc <= w_tgt_inc;
            end
            if (sample_tick) begin
              r_acc     <= w_sum[ACC_W-1:0];
              saw_out   <= w_sum[ACC_W-1 -: OUT_W];
              saw_valid <= 1'b1;
              wrap      <= w_sum[ACC_W];
              r_cur_inc <= w_glide_inc;
            end
`else
            if (w_note_chg) begin
              r_state <= LOAD;
            end else if (sample_tick) begin
              r_acc     <= w_sum[ACC_W-1:0];
              saw_out   <= w_sum[ACC_W-1 -: OUT_W];
              saw_valid <= 1'b1;
              wrap      <= w_sum[ACC_W];
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
